// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_arb_pkg: shared sizes, FSM state type and round-robin/one-hot helpers
package mux4_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W = 2;
   typedef enum logic {IDLE, GRANT} state_t;
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
      logic [SEL_W-1:0] idx;
      logic found;
      rr_pick = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/data bundle from the requesters, grant/mux result back
interface mux4_rr_arbiter_if;
   import mux4_arb_pkg::*;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] din;
   logic [NUM_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic valid;
   logic y;
   modport master (output req, din, input gnt, sel, valid, y);
   modport slave (input req, din, output gnt, sel, valid, y);
endinterface

// File: rtl/mux4to1.sv
// mux4to1: plain 4:1 bit multiplexer
module mux4to1 (
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic [1:0] sel,
   output logic       y
);
   assign y = sel[1] ? (sel[0] ? D : C) : (sel[0] ? B : A);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux with registered grant.
// Define MUX4_ARB_TIMEOUT_EN to cap each ownership at MAX_HOLD cycles.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input logic clk,
   input logic rst,
   mux4_rr_arbiter_if.slave bus
);
   state_t r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;
   logic r_valid;
   logic [SEL_W-1:0] w_pick;
   logic w_timeout;
   logic w_mux;
   assign w_pick = rr_pick(bus.req, r_ptr);
`ifdef MUX4_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] r_cnt;
   // counter holds (cycles owned - 1), so expiry lands after exactly MAX_HOLD grant cycles
   assign w_timeout = r_cnt == CW'(MAX_HOLD - 1);
   always_ff @(posedge clk) begin
      if (rst || r_state == IDLE) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_timeout = MAX_HOLD < 1;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt <= '0;
         r_sel <= '0;
         r_valid <= 1'b0;
         r_ptr <= '0;
      end else if (r_state == IDLE) begin
         if (|bus.req) begin
            r_state <= GRANT;
            r_sel <= w_pick;
            r_gnt <= to_onehot(w_pick);
            r_valid <= 1'b1;
         end
      end else if (!bus.req[r_sel] || w_timeout) begin
         r_state <= IDLE;
         r_gnt <= '0;
         r_valid <= 1'b0;
         r_ptr <= r_sel + 1'b1;
      end
   end
   mux4to1 u_mux (
      .A(bus.din[0]),
      .B(bus.din[1]),
      .C(bus.din[2]),
      .D(bus.din[3]),
      .sel(r_sel),
      .y(w_mux)
   );
   assign bus.gnt = r_gnt;
   assign bus.sel = r_sel;
   assign bus.valid = r_valid;
   assign bus.y = r_valid & w_mux;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of grant order, latency, reset and data gating
module tb_mux4_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   mux4_rr_arbiter_if bus();
   mux4_rr_arbiter #(.MAX_HOLD(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req = 4'b0000;
      bus.din = 4'b1111;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({bus.gnt, bus.sel, bus.valid, bus.y} !== 8'b0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got gnt=%b sel=%b valid=%b y=%b, exp all zero", i, bus.gnt, bus.sel, bus.valid, bus.y);
         end
      end
   endtask

   task automatic test_basic();
      bus.din = 4'b0010;
      bus.req = 4'b1010;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bus.gnt, bus.sel, bus.valid, bus.y} !== {4'b0010, 2'b01, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL basic_grant1[%0d]: got gnt=%b sel=%b valid=%b y=%b, exp 0010 01 1 1", i, bus.gnt, bus.sel, bus.valid, bus.y);
         end
      end
      bus.req = 4'b1000;
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.y} !== {4'b0000, 2'b01, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_dead: got gnt=%b sel=%b valid=%b y=%b, exp 0000 01 0 0", bus.gnt, bus.sel, bus.valid, bus.y);
      end
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.valid, bus.y} !== {4'b1000, 2'b11, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL basic_grant3: got gnt=%b sel=%b valid=%b y=%b, exp 1000 11 1 0", bus.gnt, bus.sel, bus.valid, bus.y);
      end
      bus.req = 4'b0000;
      tick();
      checks++;
      if ({bus.gnt, bus.valid} !== 5'b0) begin
         errors++;
         $display("FAIL basic_release: got gnt=%b valid=%b, exp 0000 0", bus.gnt, bus.valid);
      end
   endtask

   task automatic test_reraise();
      bus.req = 4'b0011;
      tick();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL reraise_first: got gnt=%b, exp 0001", bus.gnt);
      end
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0011;
      tick();
      checks++;
      if ({bus.gnt, bus.sel} !== {4'b0010, 2'b01}) begin
         errors++;
         $display("FAIL reraise_ptr: got gnt=%b sel=%b, exp 0010 01", bus.gnt, bus.sel);
      end
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_all_req();
      logic [3:0] exp;
      rst = 1'b1;
      bus.req = 4'b0000;
      tick();
      rst = 1'b0;
      bus.req = 4'b1111;
`ifdef MUX4_ARB_TIMEOUT_EN
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({bus.gnt, bus.valid} !== {exp, 1'b1}) begin
               errors++;
               $display("FAIL rr_hold[%0d.%0d]: got gnt=%b valid=%b, exp %b 1", k, c, bus.gnt, bus.valid, exp);
            end
         end
         tick();
         checks++;
         if ({bus.gnt, bus.valid} !== 5'b0) begin
            errors++;
            $display("FAIL rr_dead[%0d]: got gnt=%b valid=%b, exp 0000 0", k, bus.gnt, bus.valid);
         end
      end
`else
      exp = 4'b0001;
      for (int c = 0; c < 50; c++) begin
         tick();
         checks++;
         if ({bus.gnt, bus.valid} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL hold_forever[%0d]: got gnt=%b valid=%b, exp %b 1", c, bus.gnt, bus.valid, exp);
         end
      end
`endif
      bus.req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 4'b0100;
      bus.din = 4'b0000;
      tick();
      checks++;
      if ({bus.gnt, bus.sel} !== {4'b0100, 2'b10}) begin
         errors++;
         $display("FAIL mid_pre: got gnt=%b sel=%b, exp 0100 10", bus.gnt, bus.sel);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.valid} !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset: got gnt=%b sel=%b valid=%b, exp 0000 00 0", bus.gnt, bus.sel, bus.valid);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.gnt, bus.sel, bus.valid} !== {4'b0100, 2'b10, 1'b1}) begin
         errors++;
         $display("FAIL mid_regrant: got gnt=%b sel=%b valid=%b, exp 0100 10 1", bus.gnt, bus.sel, bus.valid);
      end
   endtask

   task automatic test_din_track();
      logic [3:0] dv;
      for (int d = 0; d < 16; d++) begin
         dv = 4'(d);
         bus.din = dv;
         #1;
         checks++;
         if (bus.y !== dv[2]) begin
            errors++;
            $display("FAIL din_track[%b]: got y=%b, exp %b", dv, bus.y, dv[2]);
         end
         tick();
      end
      bus.req = 4'b0000;
      bus.din = 4'b1111;
      tick();
      checks++;
      if ({bus.valid, bus.y} !== 2'b00) begin
         errors++;
         $display("FAIL din_gated: got valid=%b y=%b, exp 0 0", bus.valid, bus.y);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reraise();
      test_all_req();
      test_reset_mid();
      test_din_track();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when the timeout is compiled in; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request vector; bit i = requester i (A=0, B=1, C=2, D=3).
REQ-005 din  input  4  data bits A..D presented to the shared 4:1 mux.
REQ-006 gnt  output 4  registered one-hot grant; all-zero when no owner.
REQ-007 sel  output 2  registered mux select = index of current owner.
REQ-008 valid output 1  registered; high while an owner holds the mux.
REQ-009 y    output 1  din[sel] when valid, else 0.

Function
REQ-010 FSM SHALL have two states: IDLE (no owner), GRANT (one owner).
REQ-011 IDLE with req==0: stay IDLE; gnt=0, valid=0, sel holds its last value.
REQ-012 IDLE with req!=0: next cycle enter GRANT; owner = first set bit of req scanning upward from ptr, wrapping 3->0.
REQ-013 Grant latency SHALL be exactly 1 cycle from the req sample to gnt/valid high.
REQ-014 GRANT: gnt, sel and valid SHALL stay constant while req[owner]=1 and no timeout occurs.
REQ-015 GRANT with req[owner]=0: next cycle IDLE; ptr=(owner+1) mod 4. Exactly one dead cycle (valid=0) between owners.
REQ-016 Requests from non-owners SHALL NOT preempt the current owner.
REQ-017 Simultaneous requests in IDLE: round-robin from ptr decides; no requester waits more than 3 grants while holding req high, with the timeout compiled in.
REQ-018 Owner that drops and re-raises req in the same IDLE cycle: treated as a new request; ptr applies.
REQ-019 y SHALL be combinational from din and registered sel/valid; no added latency on data.

Reset
REQ-020 On rst=1 at a rising edge: state=IDLE, gnt=0, sel=2'b00, valid=0, ptr=0, hold counter=0.
REQ-021 Reset mid-grant SHALL drop the grant in the next cycle regardless of req.
REQ-022 rst SHALL take priority over every other transition.

Configuration
REQ-023 Macro MUX4_ARB_TIMEOUT_EN: when defined, a hold counter increments each GRANT cycle. When the owner has held MAX_HOLD cycles with req still high, the arbiter SHALL force IDLE next cycle with ptr=(owner+1) mod 4.
REQ-024 When MUX4_ARB_TIMEOUT_EN is undefined, there SHALL be no counter logic; the grant holds until req[owner] drops, and MAX_HOLD is ignored.
REQ-025 Counter width SHALL be $clog2(MAX_HOLD+1) bits.
REQ-026 The counter SHALL clear on every entry to GRANT.

Structure
REQ-027 Shared package mux4_arb_pkg SHALL hold: NUM_REQ=4, SEL_W=2, the state enum typedef (IDLE, GRANT), and the one-hot/index conversion function.
REQ-028 The data path SHALL instantiate the existing sub-module mux4to1 (ports A, B, C, D, sel, y), with its output gated by valid.
REQ-029 The round-robin priority pick SHALL be a function in the package, not a separate module.

Verification
REQ-030 Reset, then req=4'b0000 for 5 cycles -> gnt=0, valid=0, sel=00, y=0 throughout.
REQ-031 ptr=0, req=4'b1010 held -> 1 cycle later gnt=0010, sel=01, y=din[1]. Drop req[1] -> 1 IDLE cycle, then gnt=1000, sel=11.
REQ-032 All four requesters held high, timeout compiled in, MAX_HOLD=2 -> grant order 0,1,2,3,0; each owner held 2 cycles, 1 dead cycle between owners.
REQ-033 Same as REQ-032 with MUX4_ARB_TIMEOUT_EN undefined -> requester 0 holds indefinitely (checked for 50 cycles).
REQ-034 rst pulsed while gnt=0100 -> next cycle gnt=0, valid=0, sel=00. Then req=4'b0100 -> granted again with ptr=0 order.
REQ-035 Toggle din while owner is 2 -> y tracks din[2] in the same cycle; toggling din[0], din[1] and din[3] has no effect on y.
